// File: rtl/cordic_vector_iter.sv
// cordic_vector_iter: iterative CORDIC vectoring (magnitude + binary angle); define CORDIC_GAIN_COMP_EN for 1/K gain compensation
module cordic_vector_iter #(
  parameter int WIDTH = 32,
  parameter int ITER  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH+1:0] mag,
  output logic [WIDTH-1:0] angle
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ROT  = 2'd1;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [1:0] COMP = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;
  localparam int SH = 32 - WIDTH;
  localparam logic [32:0] RND = (33'd1 << SH) >> 1;
  localparam logic [5:0] LAST = 6'(ITER);
  localparam logic [31:0] ATAN [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };
  logic [1:0] state;
  logic [5:0] cnt;
  logic signed [WIDTH+1:0] x, y, xs, ys, xe, ye;
  logic [WIDTH-1:0] z, da;
  logic zin, neg, accept;
  assign done = state == DONE;
`ifdef CORDIC_GAIN_COMP_EN
  assign busy = state == ROT || state == COMP;
`else
  assign busy = state == ROT;
`endif
  // per-step shifted cross terms, width-rounded arctangent and sign-extended operands
  always_comb begin
    xs = x >>> cnt;
    ys = y >>> cnt;
    da = WIDTH'(({1'b0, ATAN[cnt[4:0]]} + RND) >> SH);
    xe = {{2{x_in[WIDTH-1]}}, x_in};
    ye = {{2{y_in[WIDTH-1]}}, y_in};
    neg = x_in[WIDTH-1];
    accept = start && !busy;
  end
  // control FSM and datapath: left-half pre-rotation on load, micro-rotations driving y to zero, then result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      x <= '0;
      y <= '0;
      z <= '0;
      zin <= 1'b0;
      mag <= '0;
      angle <= '0;
    end else if (accept) begin
      state <= ROT;
      cnt <= '0;
      x <= neg ? -xe : xe;
      y <= neg ? -ye : ye;
      z <= neg ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
      zin <= x_in == '0 && y_in == '0;
    end else if (state == ROT && cnt != LAST) begin
      x <= y[WIDTH+1] ? x - ys : x + ys;
      y <= y[WIDTH+1] ? y + xs : y - xs;
      z <= y[WIDTH+1] ? z - da : z + da;
      cnt <= cnt + 6'd1;
    end else if (state == ROT) begin
`ifdef CORDIC_GAIN_COMP_EN
      state <= COMP;
`else
      state <= DONE;
      mag <= $unsigned(x);
      angle <= zin ? '0 : z;
`endif
    end
`ifdef CORDIC_GAIN_COMP_EN
    else if (state == COMP) begin
      state <= DONE;
      mag <= (WIDTH+2)'(((WIDTH+19)'($unsigned(x)) * (WIDTH+19)'(39797) + (WIDTH+19)'(32768)) >> 16);
      angle <= zin ? '0 : z;
    end
`endif
    else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_cordic_vector_iter.sv
// tb_cordic_vector_iter: directed and randomized checks of cordic_vector_iter against a behavioural vectoring model
module tb_cordic_vector_iter;
  localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 2;
  localparam longint M_AX = 1001;
  localparam longint M_ONE = 1000;
  localparam longint M_DG = 1414;
  localparam longint M_5K = 5000;
  localparam longint M_BIG = 64'd3037000500;
`else
  localparam int LAT = ITER + 1;
  localparam longint M_AX = 1649;
  localparam longint M_ONE = 1647;
  localparam longint M_DG = 2329;
  localparam longint M_5K = 8234;
  localparam longint M_BIG = 64'd5001211727;
`endif
  logic clock = 1'b0;
  logic reset, start;
  logic [31:0] x_in, y_in;
  logic busy, done;
  logic [33:0] mag;
  logic [31:0] angle;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] atan_tab [32];
  logic m_en = 1'b0;
  logic m_busy, m_done;
  logic [33:0] m_mag, p_mag;
  logic [31:0] m_ang, p_ang;
  int m_cnt;

  cordic_vector_iter #(.WIDTH(32), .ITER(ITER)) dut (
    .clock(clock), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .mag(mag), .angle(angle)
  );

  always #5 clock = ~clock;

  initial for (int i = 0; i < 32; i++)
    atan_tab[i] = 32'(longint'($floor($atan($pow(2.0, -real'(i))) * 4294967296.0 / (2.0 * 3.141592653589793) + 0.5)));

  function automatic logic [65:0] model(input logic [31:0] xi, input logic [31:0] yi);
    longint xv, yv, t;
    logic [31:0] zv;
    xv = longint'($signed(xi));
    yv = longint'($signed(yi));
    zv = 32'd0;
    if (xv < 0) begin
      xv = -xv;
      yv = -yv;
      zv = 32'h80000000;
    end
    for (int i = 0; i < ITER; i++) begin
      t = xv;
      if (yv >= 0) begin
        xv = xv + (yv >>> i);
        yv = yv - (t >>> i);
        zv = zv + atan_tab[i];
      end else begin
        xv = xv - (yv >>> i);
        yv = yv + (t >>> i);
        zv = zv - atan_tab[i];
      end
    end
`ifdef CORDIC_GAIN_COMP_EN
    xv = (xv * 39797 + 32768) >>> 16;
`endif
    if (xi == 32'd0 && yi == 32'd0) zv = 32'd0;
    return {34'(xv), zv};
  endfunction

  task automatic check(input string nm, input longint act, input longint exp, input longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    n_chk++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", nm, act, exp, tol, $time);
    end
  endtask

  task automatic check_ang(input string nm, input logic [31:0] act, input logic [31:0] exp, input longint tol);
    longint d;
    d = longint'($signed(act - exp));
    if (d < 0) d = -d;
    n_chk++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (tol %0d) at %0t", nm, act, exp, tol, $time);
    end
  endtask

  // reference timing: accept when idle, result LAT edges later, done for one cycle
  always @(posedge clock) begin
    if (reset) begin
      m_en <= 1'b1;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_mag <= '0;
      m_ang <= '0;
      m_cnt <= 0;
    end else if (!m_busy && start) begin
      {p_mag, p_ang} <= model(x_in, y_in);
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_cnt <= LAT;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_mag <= p_mag;
        m_ang <= p_ang;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clock) if (m_en) begin
    check("busy", longint'(busy), longint'(m_busy), 0);
    check("done", longint'(done), longint'(m_done), 0);
    check("mag", longint'(mag), longint'(m_mag), 0);
    check_ang("angle", angle, m_ang, 0);
  end

  task automatic run_vec(input string nm, input logic [31:0] xv, input logic [31:0] yv,
                         input longint em, input longint mt, input logic [31:0] ea, input longint at);
    int n;
    logic got;
    start = 1'b1;
    x_in = xv;
    y_in = yv;
    @(posedge clock); #1;
    start = 1'b0;
    x_in = $urandom;
    y_in = $urandom;
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clock);
      n++;
      got = done;
    end
    check({nm, "_latency"}, longint'(n - 1), longint'(LAT), 0);
    check({nm, "_mag"}, longint'(mag), em, mt);
    check_ang({nm, "_angle"}, angle, ea, at);
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 7))
      0: return 32'h80000000;
      1: return 32'h7FFFFFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 2000)) - 32'd1000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, c;
    int ts [4];
    reset = 1'b1;
    start = 1'b0;
    x_in = '0;
    y_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", longint'(busy), 0, 0);
    check("rst_done", longint'(done), 0, 0);
    check("rst_mag", longint'(mag), 0, 0);
    check("rst_angle", longint'(angle), 0, 0);
    reset = 1'b0;
    run_vec("x1000", 32'd1000, 32'd0, M_AX, 0, 32'd780682, 0);
    run_vec("y1000", 32'd0, 32'd1000, M_ONE, 6, 32'h40000000, 2097152);
    run_vec("xm1000", -32'd1000, 32'd0, M_ONE, 6, 32'h80000000, 2097152);
    run_vec("diag", -32'd1000, -32'd1000, M_DG, 6, 32'hA0000000, 2097152);
    run_vec("zero", 32'd0, 32'd0, 0, 0, 32'd0, 0);
    run_vec("minneg", 32'h80000000, 32'h80000000, M_BIG, 65536, 32'hA0000000, 65536);
    start = 1'b1;
    x_in = 32'd3000;
    y_in = 32'd4000;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1;
    x_in = -32'd5;
    y_in = 32'd77;
    @(posedge clock); #1;
    start = 1'b0;
    nd = 0;
    repeat (LAT + 10) begin
      @(negedge clock);
      if (done) begin
        nd++;
        check("ignored_mag", longint'(mag), M_5K, 8);
        check_ang("ignored_angle", angle, 32'd633866811, 2097152);
      end
    end
    check("ignored_dones", longint'(nd), 1, 0);
    @(posedge clock); #1;
    start = 1'b1;
    x_in = 32'd1000;
    y_in = 32'd500;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    start = 1'b0;
    check("abort_busy", longint'(busy), 0, 0);
    check("abort_done", longint'(done), 0, 0);
    check("abort_mag", longint'(mag), 0, 0);
    check("abort_angle", longint'(angle), 0, 0);
    nd = 0;
    repeat (LAT + 5) begin
      @(negedge clock);
      if (done) nd++;
    end
    check("abort_no_done", longint'(nd), 0, 0);
    @(posedge clock); #1;
    run_vec("after_abort", 32'd0, 32'd1000, M_ONE, 6, 32'h40000000, 2097152);
    start = 1'b1;
    c = 0;
    nd = 0;
    while (nd < 4 && c < 6 * (LAT + 1)) begin
      x_in = rnd();
      y_in = rnd();
      @(posedge clock); #1;
      c++;
      if (done) begin
        ts[nd] = c;
        nd++;
      end
    end
    start = 1'b0;
    check("stream_dones", longint'(nd), 4, 0);
    for (int k = 1; k < nd; k++) check("stream_period", longint'(ts[k] - ts[k-1]), longint'(LAT + 1), 0);
    repeat (LAT + 3) @(posedge clock);
    #1;
    nd = 0;
    repeat (3000) begin
      start = $urandom_range(0, 2) == 0;
      reset = $urandom_range(0, 599) == 0;
      x_in = rnd();
      y_in = rnd();
      @(posedge clock); #1;
      if (done) nd++;
    end
    reset = 1'b0;
    start = 1'b0;
    check("random_dones_seen", longint'(nd > 50), 1, 0);
    repeat (LAT + 3) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
